// File: rtl/integer_alu.sv
// Register-mapped integer ALU: ADD/SUB complete in one calculation cycle,
// MUL (shift-add) and DIV (restoring) iterate one operand bit per cycle.
module integer_alu #(
    parameter int UNIT_ID = 3,
    parameter int OPW     = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [15:0]  address,
    input  logic         nRead,
    input  logic         nWrite,
    input  logic [255:0] ExeDataOut,
    output logic [255:0] IntDataOut,
    output logic         IntErr
);
    localparam int         CW     = $clog2(OPW + 1);
    localparam logic [7:0] OP_ADD = 8'h10;
    localparam logic [7:0] OP_SUB = 8'h11;
    localparam logic [7:0] OP_MUL = 8'h12;
    localparam logic [7:0] OP_DIV = 8'h13;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state_q, state_d;
    logic [255:0]     src1_q, src1_d, src2_q, src2_d, result_q, result_d;
    logic [7:0]       status_in_q, status_in_d;
    logic             status_out_q, status_out_d;
    logic             int_err_q, int_err_d;
    logic [OPW-1:0]   work_a_q, work_a_d;
    logic [2*OPW-1:0] work_p_q, work_p_d;
    logic [CW-1:0]    count_q, count_d;

    logic             unit_sel, wr_en, rd_en;
    logic [4:0]       idx_hit;

    assign unit_sel = (address[15:12] == UNIT_ID[3:0]);
    assign wr_en    = unit_sel && !nWrite;
    assign rd_en    = unit_sel && !nRead;

    for (genvar gi = 0; gi < 5; gi++) begin : g_idx
        assign idx_hit[gi] = (address[11:0] == 12'(gi));
    end

    always_comb begin
        IntDataOut = '0;
        if (rd_en) begin
            if (idx_hit[0]) IntDataOut = src1_q;
            if (idx_hit[1]) IntDataOut = src2_q;
            if (idx_hit[2]) IntDataOut = result_q;
            if (idx_hit[3]) IntDataOut = {248'b0, status_in_q};
            if (idx_hit[4]) IntDataOut = {255'b0, status_out_q};
        end
    end

    assign IntErr = int_err_q;

    // Datapath for one calculation step; work_p holds {hi, lo} for MUL and {rem, quo} for DIV.
    logic [OPW:0] sum_ext, diff_ext, mul_sum, div_shift, div_trial;
    always_comb begin
        sum_ext   = {1'b0, work_a_q} + {1'b0, work_p_q[OPW-1:0]};
        diff_ext  = {1'b0, work_a_q} - {1'b0, work_p_q[OPW-1:0]};
        mul_sum   = {1'b0, work_p_q[2*OPW-1:OPW]} + (work_p_q[0] ? {1'b0, work_a_q} : '0);
        div_shift = work_p_q[2*OPW-1:OPW-1];
        div_trial = div_shift - {1'b0, work_a_q};
    end

    always_comb begin
        state_d      = state_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        result_d     = result_q;
        status_in_d  = status_in_q;
        status_out_d = status_out_q;
        int_err_d    = int_err_q;
        work_a_d     = work_a_q;
        work_p_d     = work_p_q;
        count_d      = count_q;
        case (state_q)
            IDLE: begin
                if (wr_en && idx_hit[0]) src1_d = ExeDataOut;
                if (wr_en && idx_hit[1]) src2_d = ExeDataOut;
                if (wr_en && idx_hit[3]) begin
                    status_in_d  = ExeDataOut[7:0];
                    status_out_d = 1'b0;
                    int_err_d    = 1'b0;
                    count_d      = '0;
                    state_d      = CALC;
                    // DIV keeps the divisor in work_a and the dividend in the low half of work_p.
                    if (ExeDataOut[7:0] == OP_DIV) begin
                        work_a_d = src2_q[OPW-1:0];
                        work_p_d = {{OPW{1'b0}}, src1_q[OPW-1:0]};
                    end else begin
                        work_a_d = src1_q[OPW-1:0];
                        work_p_d = {{OPW{1'b0}}, src2_q[OPW-1:0]};
                    end
                end
            end
            CALC: begin
                case (status_in_q)
                    OP_ADD: begin
                        work_p_d = {{(OPW-1){1'b0}}, sum_ext};
                        state_d  = FINISH;
                    end
                    OP_SUB: begin
                        work_p_d = {{(OPW-1){1'b0}}, diff_ext};
                        state_d  = FINISH;
                    end
                    OP_MUL, OP_DIV: begin
                        if (count_q == OPW[CW-1:0]) begin
                            state_d = FINISH;
                        end else begin
                            count_d = count_q + CW'(1);
                            if (status_in_q == OP_MUL)
                                work_p_d = {mul_sum, work_p_q[OPW-1:1]};
                            else
                                work_p_d = {div_trial[OPW] ? div_shift[OPW-1:0] : div_trial[OPW-1:0],
                                            work_p_q[OPW-2:0], ~div_trial[OPW]};
                        end
                    end
                    default: begin
                        work_p_d = '0;
                        state_d  = FINISH;
                    end
                endcase
            end
            FINISH: begin
                result_d     = {{(256-2*OPW){1'b0}}, work_p_q};
                status_out_d = 1'b1;
                int_err_d    = !(status_in_q inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV}) ||
                               (status_in_q == OP_DIV && work_a_q == '0);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            src1_q       <= '0;
            src2_q       <= '0;
            result_q     <= '0;
            status_in_q  <= '0;
            status_out_q <= 1'b0;
            int_err_q    <= 1'b0;
            work_a_q     <= '0;
            work_p_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            result_q     <= result_d;
            status_in_q  <= status_in_d;
            status_out_q <= status_out_d;
            int_err_q    <= int_err_d;
            work_a_q     <= work_a_d;
            work_p_q     <= work_p_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_integer_alu.sv
// Scoreboard bench for integer_alu: stimulus pushes expected responses, a monitor
// process polls status_out and compares result, error flag and latency.
module tb_integer_alu;
    localparam int         OPW  = 32;
    localparam logic [3:0] UNIT = 4'd3;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [15:0]  address;
    logic         nRead;
    logic         nWrite;
    logic [255:0] ExeDataOut;
    logic [255:0] IntDataOut;
    logic         IntErr;

    logic [15:0]  s_addr = '0, m_addr = '0;
    logic         s_nread = 1'b1, m_active = 1'b0;

    assign address = m_active ? m_addr : s_addr;
    assign nRead   = m_active ? 1'b0 : s_nread;

    integer_alu #(.UNIT_ID(3), .OPW(OPW)) dut (
        .Clk(Clk), .Reset(Reset), .address(address), .nRead(nRead), .nWrite(nWrite),
        .ExeDataOut(ExeDataOut), .IntDataOut(IntDataOut), .IntErr(IntErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [255:0] res;
        logic         err;
        int           lat;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0, failures = 0, issued = 0, checked = 0;
    logic [255:0] last_res = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: plain arithmetic on the 32-bit operands.
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned wa = 64'(a);
        longint unsigned wb = 64'(b);
        e.res = '0; e.err = 1'b0; e.lat = 2;
        e.name = $sformatf("op%02h_%0h_%0h", op, a, b);
        case (op)
            8'h10: e.res = 256'(wa + wb);
            8'h11: e.res = 256'((wa - wb) & 64'h1_FFFF_FFFF);
            8'h12: begin e.res = 256'(wa * wb); e.lat = OPW + 2; end
            8'h13: begin
                e.lat = OPW + 2;
                if (b == 0) begin
                    e.res = {192'b0, a, 32'hFFFF_FFFF};
                    e.err = 1'b1;
                end else begin
                    e.res = {192'b0, a % b, a / b};
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic wr(input logic [3:0] unit, input logic [11:0] idx, input logic [255:0] data);
        s_addr = {unit, idx};
        ExeDataOut = data;
        nWrite = 1'b0;
        @(posedge Clk); #1;
        nWrite = 1'b1;
    endtask

    task automatic rd(input logic [3:0] unit, input logic [11:0] idx, output logic [255:0] data);
        s_addr = {unit, idx};
        s_nread = 1'b0;
        #2;
        data = IntDataOut;
        s_nread = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [223:0] hi_junk);
        exp_t e;
        int   c;
        wr(UNIT, 12'd0, {hi_junk, a});
        wr(UNIT, 12'd1, {~hi_junk, b});
        wr(UNIT, 12'd3, {248'b0, op});
        e = model(op, a, b);
        last_res = e.res;
        sb_q.push_back(e);
        issued++;
        c = 0;
        while (checked < issued && c < 300) begin
            @(posedge Clk);
            c++;
        end
        #1;
        if (checked < issued) begin
            failures++;
            $display("FAIL timeout_%s actual=pending required=done", e.name);
            $fatal(1, "monitor did not complete");
        end
    endtask

    // Monitor: owns the read bus while an operation is outstanding.
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(posedge Clk);
            if (sb_q.size() != 0) begin
                m_active = 1'b1;
                m_addr = {UNIT, 12'd4};
                k = 1;
                #1;
                while (IntDataOut[0] !== 1'b1 && k < 200) begin
                    @(posedge Clk); #1;
                    k++;
                end
                e = sb_q.pop_front();
                check({"lat_", e.name}, 256'(k), 256'(e.lat));
                check({"status_", e.name}, IntDataOut, 256'h1);
                m_addr = {UNIT, 12'd2};
                #1;
                check({"result_", e.name}, IntDataOut, e.res);
                check({"err_", e.name}, 256'(IntErr), 256'(e.err));
                m_active = 1'b0;
                checked++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        logic [7:0]   op;
        logic [31:0]  a, b;
        logic [7:0]   illegal_ops [4];
        illegal_ops[0] = 8'h00; illegal_ops[1] = 8'h1F;
        illegal_ops[2] = 8'hFF; illegal_ops[3] = 8'h14;

        Reset = 1'b1; nWrite = 1'b1; ExeDataOut = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        check("reset_interr", 256'(IntErr), 256'h0);
        for (int i = 0; i < 5; i++) begin
            rd(UNIT, 12'(i), d);
            check($sformatf("reset_reg%0d", i), d, '0);
        end

        run_op(8'h10, 32'd5, 32'd7, '0);
        run_op(8'h11, 32'd3, 32'd5, '0);
        run_op(8'h12, 32'hFFFF_FFFF, 32'd2, '0);
        run_op(8'h13, 32'd100, 32'd7, '0);
        run_op(8'h13, 32'd9, 32'd0, '0);
        run_op(8'h1F, 32'd11, 32'd13, '0);

        rd(UNIT, 12'd3, d);
        check("status_in_readback", d, 256'h1F);
        wr(4'd2, 12'd0, 256'hABCD);
        rd(4'd2, 12'd0, d);
        check("other_unit_read", d, '0);
        rd(UNIT, 12'd0, d);
        check("other_unit_write_ignored", d, 256'd11);
        rd(UNIT, 12'd5, d);
        check("unmapped_read", d, '0);
        wr(UNIT, 12'd2, 256'h55);
        rd(UNIT, 12'd2, d);
        check("result_not_writable", d, last_res);

        // MUL interrupted by reset; writes during CALC must be ignored
        wr(UNIT, 12'd0, 256'd6);
        wr(UNIT, 12'd1, 256'd9);
        wr(UNIT, 12'd3, 256'h12);
        wr(UNIT, 12'd0, 256'hDEAD);
        wr(UNIT, 12'd3, 256'h10);
        rd(UNIT, 12'd0, d);
        check("calc_write_ignored", d, 256'd6);
        rd(UNIT, 12'd4, d);
        check("calc_status_zero", d, '0);
        rd(UNIT, 12'd2, d);
        check("calc_prev_result", d, last_res);
        repeat (5) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        check("midop_reset_interr", 256'(IntErr), 256'h0);
        for (int i = 0; i < 5; i++) begin
            rd(UNIT, 12'(i), d);
            check($sformatf("midop_reset_reg%0d", i), d, '0);
        end
        run_op(8'h10, 32'd1, 32'd1, '0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 8'h10;
                1: op = 8'h11;
                2: op = 8'h12;
                3: op = 8'h13;
                default: op = illegal_ops[$urandom_range(0, 3)];
            endcase
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op(op, a, b, {7{$urandom}});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/integer_alu.md
INTEGER_ALU -- requirements
Module: integer_alu

Interface
REQ-001 The block SHALL have parameter UNIT_ID, default 3, the address[15:12] nibble that selects this unit.
REQ-002 The block SHALL have parameter OPW, default 32, the operand width taken from bits [OPW-1:0] of the source registers.
REQ-003 The block SHALL have one clock and synchronous active-high reset; all state SHALL update on the rising edge of Clk.
REQ-004 Clk  input  1  system clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 address  input  16  [15:12] unit select; [11:0] register index.
REQ-007 nRead  input  1  active-low read strobe.
REQ-008 nWrite  input  1  active-low write strobe.
REQ-009 ExeDataOut  input  256  write data from the execution engine.
REQ-010 IntDataOut  output  256  read data to the execution engine.
REQ-011 IntErr  output  1  error flag for the last operation.

Function
REQ-012 Register map by index: 0 src1, 1 src2, 2 result, 3 status_in (opcode, bits [7:0]), 4 status_out; indices above 4 are unmapped.
REQ-013 A write SHALL occur on a rising edge when nWrite=0 and address[15:12]=UNIT_ID; only indices 0, 1 and 3 are writable, and writes to 2, 4 or above 4 are ignored.
REQ-014 IntDataOut SHALL be combinational: the selected register when nRead=0, address[15:12]=UNIT_ID and index<=4; otherwise 256'h0.
REQ-015 The FSM SHALL have states IDLE, CALC and FINISH.
REQ-016 In IDLE, a write to index 3 SHALL latch the opcode, copy src1/src2[OPW-1:0] into working registers, clear status_out to 0 and IntErr to 0, clear the iteration count, and go to CALC.
REQ-017 Opcodes: 8'h10 ADD, 8'h11 SUB, 8'h12 MUL, 8'h13 DIV; any other opcode is illegal.
REQ-018 ADD: result = zero-extended {carry, sum}, 33 bits.
REQ-019 SUB: result = zero-extended {borrow, difference mod 2^32}.
REQ-020 ADD, SUB and illegal opcodes SHALL go CALC->FINISH after 1 cycle.
REQ-021 MUL SHALL be an unsigned shift-add over OPW iterations, one per cycle in CALC, giving a 64-bit product in result[63:0].
REQ-022 DIV SHALL be an unsigned restoring division over OPW iterations, one per cycle, giving quotient in result[31:0] and remainder in result[63:32].
REQ-023 Divide by zero SHALL give quotient 32'hFFFFFFFF, remainder = dividend, IntErr=1, with the same latency as DIV.
REQ-024 An illegal opcode SHALL give result=0 and IntErr=1.
REQ-025 FINISH SHALL write result, set status_out=256'h1, and return to IDLE on the next edge.
REQ-026 Latency from the start edge N: ADD/SUB/illegal have status_out=1 visible after edge N+2; MUL/DIV have it visible after edge N+OPW+2.
REQ-027 In CALC and FINISH, writes to indices 0, 1 and 3 SHALL be ignored; a read of index 2 returns the previous result and a read of index 4 returns 0.
REQ-028 The result register and status_out=1 SHALL hold until the next start; operand registers hold their last written values.
REQ-029 A write to index 3 in the same cycle as an operand write is impossible on one bus; back-to-back starts in consecutive IDLE cycles are each accepted.

Reset
REQ-030 Reset=1 on a rising edge SHALL force IDLE and clear src1, src2, result, status_in, status_out, working registers, the iteration count and IntErr to 0, regardless of state; the reset value of IntErr is 0.
REQ-031 Reset SHALL take priority over any simultaneous write; IntDataOut SHALL still follow REQ-014 during reset.

Verification
REQ-032 Write src1=5, src2=7, opcode 8'h10 -> status_out=1 after edge N+2; result=12; IntErr=0.
REQ-033 src1=3, src2=5, opcode 8'h11 -> result=33'h1_FFFFFFFE.
REQ-034 src1=32'hFFFFFFFF, src2=2, opcode 8'h12 -> status_out=0 through edge N+33 and 1 after N+34; result=64'h1_FFFFFFFE.
REQ-035 DIV 100/7 -> result[31:0]=14, result[63:32]=2; DIV 9/0 -> quotient FFFFFFFF, remainder 9, IntErr=1.
REQ-036 Assert Reset 10 cycles into a MUL -> state IDLE and all registers 0; a subsequent ADD 1+1 gives 2.
REQ-037 Opcode 8'h1F -> result 0, IntErr=1, status_out=1; a write with address[15:12]=2 changes nothing and reads return 0.
